// File: rtl/request_queue.sv
// Global definitions shared with the parser, followed by request_queue:
// a bounded in-order queue that captures parsed ops with their arrival
// CPU cycle and presents the oldest one to the DRAM scheduler.

package global_defs;

  // Width of a DRAM op address as produced by the parser.
  localparam int ADDRESS_WIDTH = 36;

  // Op codes produced by the parser; NOP marks "nothing to schedule".
  typedef enum logic [1:0] {
    NOP     = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    REFRESH = 2'd3
  } parsed_op_t;

endpackage : global_defs

// request_queue
// Strobed ops (opcode, address, arrival timestamp) are appended at the
// write pointer; the entry at the read pointer is shown first-word-fall-
// through on out_*. Occupancy is tracked by an explicit count so that
// full and empty never depend on pointer comparison. An op that arrives
// while the queue is full and nothing leaves is dropped and remembered
// in the sticky err_overflow flag.
module request_queue
  import global_defs::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           op_ready_s,
  input  parsed_op_t                     opcode,
  input  logic [ADDRESS_WIDTH-1:0]       address,
  input  logic [TS_WIDTH-1:0]            CPU_cycle_count,
  output logic                           q_full,
  output logic                           q_empty,
  output logic [$clog2(DEPTH+1)-1:0]     q_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  output parsed_op_t                     out_opcode,
  output logic [ADDRESS_WIDTH-1:0]       out_address,
  output logic [TS_WIDTH-1:0]            out_arrival,
  output logic                           err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR    = PW'(1);

  // Entry storage; deliberately not reset, only pointers and count are.
  parsed_op_t                 mem_op_r   [DEPTH];
  logic [ADDRESS_WIDTH-1:0]   mem_addr_r [DEPTH];
  logic [TS_WIDTH-1:0]        mem_ts_r   [DEPTH];

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic push_req_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic full_s;
  logic empty_s;

  // Decode occupancy and the per-cycle push/pop/drop decisions.
  always_comb begin
    full_s     = (count_r == FULL_COUNT);
    empty_s    = (count_r == '0);
    push_req_s = op_ready_s && (opcode != NOP);
    pop_s      = !empty_s && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    if (push_req_s && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (push_req_s && full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Write an accepted op into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_op_r[wr_ptr_r]   <= opcode;
      mem_addr_r[wr_ptr_r] <= address;
      mem_ts_r[wr_ptr_r]   <= CPU_cycle_count;
    end
  end

  // Advance pointers and occupancy; async reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_COUNT;
        2'b01:   count_r <= count_r - ONE_COUNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Remember any op lost to overflow until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Present the head entry; an empty queue shows a clean NOP.
  always_comb begin
    q_full       = full_s;
    q_empty      = empty_s;
    q_count      = count_r;
    out_valid    = !empty_s;
    err_overflow = overflow_r;
    if (empty_s) begin
      out_opcode  = NOP;
      out_address = '0;
      out_arrival = '0;
    end else begin
      out_opcode  = mem_op_r[rd_ptr_r];
      out_address = mem_addr_r[rd_ptr_r];
      out_arrival = mem_ts_r[rd_ptr_r];
    end
  end

endmodule : request_queue

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue: directed steps plus a randomized
// phase, all compared against a queue-based reference model.
module tb_request_queue;
  import global_defs::*;

  localparam int DEPTH    = 16;
  localparam int TS_WIDTH = 32;
  localparam int AW       = ADDRESS_WIDTH;
  localparam int CW       = $clog2(DEPTH+1);

  typedef struct {
    parsed_op_t          op;
    logic [AW-1:0]       addr;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                op_ready_s = 1'b0;
  parsed_op_t          opcode = NOP;
  logic [AW-1:0]       address = '0;
  logic [TS_WIDTH-1:0] CPU_cycle_count = '0;
  logic                q_full;
  logic                q_empty;
  logic [CW-1:0]       q_count;
  logic                out_valid;
  logic                out_ready = 1'b0;
  parsed_op_t          out_opcode;
  logic [AW-1:0]       out_address;
  logic [TS_WIDTH-1:0] out_arrival;
  logic                err_overflow;

  int checks = 0;
  int errors = 0;

  entry_t              mq[$];
  bit                  m_ovf = 1'b0;
  logic [TS_WIDTH-1:0] cpu_cnt = '0;

  request_queue #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk(clk), .rst(rst), .op_ready_s(op_ready_s), .opcode(opcode),
    .address(address), .CPU_cycle_count(CPU_cycle_count),
    .q_full(q_full), .q_empty(q_empty), .q_count(q_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_address(out_address), .out_arrival(out_arrival),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_outputs();
    bit e;
    e = (mq.size() == 0);
    chk("q_count", 64'(q_count), 64'(mq.size()));
    chk("q_empty", 64'(q_empty), 64'(e));
    chk("q_full", 64'(q_full), 64'(mq.size() == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(!e));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    if (e) begin
      chk("out_opcode", 64'(out_opcode), 64'(NOP));
      chk("out_address", 64'(out_address), 64'd0);
      chk("out_arrival", 64'(out_arrival), 64'd0);
    end else begin
      chk("out_opcode", 64'(out_opcode), 64'(mq[0].op));
      chk("out_address", 64'(out_address), 64'(mq[0].addr));
      chk("out_arrival", 64'(out_arrival), 64'(mq[0].ts));
    end
  endtask

  // One clock cycle: drive inputs, check, update model, cross the edge.
  task automatic cycle(input bit ors, input parsed_op_t opc, input logic [AW-1:0] a, input bit ordy);
    bit pop;
    bit preq;
    bit full;
    entry_t ent;
    op_ready_s      = ors;
    opcode          = opc;
    address         = a;
    out_ready       = ordy;
    CPU_cycle_count = cpu_cnt;
    #1;
    check_outputs();
    pop  = (mq.size() != 0) && ordy;
    preq = ors && (opc != NOP);
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (preq) begin
      if (full && !pop) begin
        m_ovf = 1'b1;
      end else begin
        ent.op = opc; ent.addr = a; ent.ts = cpu_cnt;
        mq.push_back(ent);
      end
    end
    @(posedge clk);
    #1;
    cpu_cnt = cpu_cnt + 32'd1;
  endtask

  task automatic do_reset();
    op_ready_s = 1'b0;
    out_ready  = 1'b0;
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  initial begin
    // Power-on reset, checked while still asserted.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Idle for 20 cycles: outputs stay at reset values.
    for (int i = 0; i < 20; i++) cycle(1'b0, NOP, '0, 1'b0);

    // Single op with a known timestamp, then pop it.
    cpu_cnt = 32'd5;
    cycle(1'b1, READ, 36'h1_2345_6780, 1'b0);
    cycle(1'b0, NOP, '0, 1'b1);
    cycle(1'b0, NOP, '0, 1'b0);

    // Fill to 16, overflow with a 17th, drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, WRITE, AW'(i), 1'b0);
    cycle(1'b1, READ, 36'h10, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, NOP, '0, 1'b1);
    cycle(1'b0, NOP, '0, 1'b0);

    // 20 more ops with interleaved pops, across the pointer wrap.
    for (int i = 0; i < 20; i++) cycle(1'b1, READ, AW'(36'h100 + i), i[0]);
    while (mq.size() != 0) cycle(1'b0, NOP, '0, 1'b1);

    // Full queue with simultaneous push and pop: no overflow.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, READ, AW'(36'h200 + i), 1'b0);
    cycle(1'b1, WRITE, 36'hAA, 1'b1);
    cycle(1'b0, NOP, '0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, NOP, '0, 1'b1);

    // NOP strobes on empty and non-empty queues are ignored.
    cycle(1'b1, NOP, 36'h55, 1'b0);
    cycle(1'b1, REFRESH, 36'h56, 1'b0);
    cycle(1'b1, NOP, 36'h57, 1'b0);
    cycle(1'b1, NOP, 36'h58, 1'b1);
    cycle(1'b0, NOP, '0, 1'b0);

    // Randomized traffic: fill-biased first half, drain-biased second.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, parsed_op_t'($urandom_range(0, 3)),
            rand_addr(), $urandom_range(0, 99) < ((i < 200) ? 30 : 70));
    end

    // Force an overflow, then settle at exactly 7 entries.
    while (mq.size() != 0) cycle(1'b0, NOP, '0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, WRITE, rand_addr(), 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, NOP, '0, 1'b1);
    out_ready = 1'b0;
    #1;
    check_outputs();

    // Async reset between edges clears state without a clock edge.
    op_ready_s = 1'b1;
    opcode     = READ;
    address    = 36'h3_0000_0001;
    #1;
    rst = 1'b1;
    #1;
    chk("async_q_count", 64'(q_count), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_err_overflow", 64'(err_overflow), 64'd0);
    chk("async_q_empty", 64'(q_empty), 64'd1);
    mq.delete();
    m_ovf = 1'b0;
    // Strobe held across an edge during reset is discarded.
    @(posedge clk);
    #1;
    check_outputs();
    op_ready_s = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, WRITE, 36'h4_5678_9ABC, 1'b0);
    cycle(1'b0, NOP, '0, 1'b1);
    cycle(1'b0, NOP, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_request_queue
